// File: rtl/cache_fill_arbiter.sv
// Round-robin block-fill arbiter: NUM_CH caches share one pipelined memory read port.
// Optional critical-word-first ordering is enabled by defining CRITICAL_WORD_FIRST_EN.
module cache_fill_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int DWIDTH      = 16,
    parameter int AWIDTH      = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int WORD_BYTES  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        miss_req,
    input  logic [NUM_CH*AWIDTH-1:0] miss_addr,
    input  logic [DWIDTH-1:0]        mem_data_in,
    input  logic                     mem_data_valid,
    output logic                     mem_rd_en,
    output logic [AWIDTH-1:0]        mem_addr,
    output logic [DWIDTH-1:0]        fill_data,
    output logic [AWIDTH-1:0]        fill_addr,
    output logic [NUM_CH-1:0]        fsm_data_wen,
    output logic [NUM_CH-1:0]        fsm_tag_wen,
    output logic [NUM_CH-1:0]        grant,
    output logic                     busy
);

    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WIDX     = $clog2(BLOCK_WORDS);
    localparam int CNT_W    = WIDX + 1;
    localparam int WB_SH    = $clog2(WORD_BYTES);
    localparam int OFF_BITS = $clog2(BLOCK_WORDS * WORD_BYTES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_TAG   = 2'd3;

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [AWIDTH-1:0] BASE_MASK = {AWIDTH{1'b1}} << OFF_BITS;

    function automatic logic [AWIDTH-1:0] word_addr(input logic [AWIDTH-1:0] base,
                                                    input logic [WIDX-1:0]   off);
        return base + (AWIDTH'(off) << WB_SH);
    endfunction

    logic [1:0]        r_state;
    logic [CH_W-1:0]   r_ch;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [AWIDTH-1:0] r_base;
    logic [WIDX-1:0]   r_start;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic [CNT_W-1:0]  r_ret_cnt;

    logic [1:0]        w_next_state;
    logic              w_found;
    logic [CH_W-1:0]   w_sel_ch;
    logic [CH_W-1:0]   w_idx;
    logic [AWIDTH-1:0] w_req_addr;
    logic [NUM_CH-1:0] w_ch_oh;
    logic              w_fill_phase;
    logic              w_ret_ok;
    logic [CNT_W-1:0]  w_ret_next;
    logic [WIDX-1:0]   w_issue_off;
    logic [WIDX-1:0]   w_ret_off;

    // Round-robin search: first requesting channel at or above r_rr_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_sel_ch = {CH_W{1'b0}};
        w_idx    = {CH_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
            if (!w_found && miss_req[w_idx]) begin
                w_found  = 1'b1;
                w_sel_ch = w_idx;
            end else begin
                w_found  = w_found;
            end
        end
    end

    assign w_req_addr   = miss_addr[w_sel_ch*AWIDTH +: AWIDTH];
    assign w_ch_oh      = NUM_CH'(1'b1) << r_ch;
    assign w_fill_phase = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_ret_ok     = w_fill_phase && mem_data_valid && (r_ret_cnt < CNT_FULL);
    assign w_ret_next   = r_ret_cnt + CNT_W'(w_ret_ok);
    assign w_issue_off  = r_start + r_issue_cnt[WIDX-1:0];
    assign w_ret_off    = r_start + r_ret_cnt[WIDX-1:0];

    // Next-state decode; the tag cycle follows once every word is issued and returned.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_next_state = S_ISSUE;
                else         w_next_state = S_IDLE;
            end
            S_ISSUE: begin
                if (r_issue_cnt == CNT_LAST) begin
                    if (w_ret_next == CNT_FULL) w_next_state = S_TAG;
                    else                        w_next_state = S_DRAIN;
                end else begin
                    w_next_state = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (w_ret_next == CNT_FULL) w_next_state = S_TAG;
                else                        w_next_state = S_DRAIN;
            end
            S_TAG:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, grant latch, counters and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ch        <= {CH_W{1'b0}};
            r_rr_ptr    <= {CH_W{1'b0}};
            r_base      <= {AWIDTH{1'b0}};
            r_start     <= {WIDX{1'b0}};
            r_issue_cnt <= {CNT_W{1'b0}};
            r_ret_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_ch        <= w_sel_ch;
                        r_base      <= w_req_addr & BASE_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
                        r_start     <= w_req_addr[WB_SH +: WIDX];
`else
                        r_start     <= {WIDX{1'b0}};
`endif
                        r_issue_cnt <= {CNT_W{1'b0}};
                        r_ret_cnt   <= {CNT_W{1'b0}};
                    end else begin
                        r_ch <= r_ch;
                    end
                end
                S_ISSUE: begin
                    r_issue_cnt <= r_issue_cnt + CNT_W'(1'b1);
                    r_ret_cnt   <= w_ret_next;
                end
                S_DRAIN: r_ret_cnt <= w_ret_next;
                S_TAG:   r_rr_ptr  <= (r_ch == CH_LAST) ? {CH_W{1'b0}} : r_ch + CH_W'(1'b1);
                default: r_ret_cnt <= r_ret_cnt;
            endcase
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign grant        = busy ? w_ch_oh : {NUM_CH{1'b0}};
    assign mem_rd_en    = (r_state == S_ISSUE);
    assign mem_addr     = mem_rd_en ? word_addr(r_base, w_issue_off) : {AWIDTH{1'b0}};
    assign fill_data    = mem_data_in;
    assign fsm_data_wen = w_ret_ok ? w_ch_oh : {NUM_CH{1'b0}};
    assign fsm_tag_wen  = (r_state == S_TAG) ? w_ch_oh : {NUM_CH{1'b0}};

    // Fill address tracks the return being written, or the block base on the tag cycle.
    always_comb begin
        fill_addr = {AWIDTH{1'b0}};
        if (w_ret_ok) begin
            fill_addr = word_addr(r_base, w_ret_off);
        end else if (r_state == S_TAG) begin
            fill_addr = r_base;
        end else begin
            fill_addr = {AWIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed + randomized bench for cache_fill_arbiter with a fixed-latency memory model.
module tb_cache_fill_arbiter;

    localparam int NUM_CH = 2;
    localparam int DW     = 16;
    localparam int AW     = 16;
    localparam int BW     = 8;
    localparam int WB     = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_CH-1:0]    miss_req;
    logic [NUM_CH*AW-1:0] miss_addr;
    logic [DW-1:0]        mem_data_in;
    logic                 mem_data_valid;
    logic                 mem_rd_en;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        fill_data;
    logic [AW-1:0]        fill_addr;
    logic [NUM_CH-1:0]    fsm_data_wen;
    logic [NUM_CH-1:0]    fsm_tag_wen;
    logic [NUM_CH-1:0]    grant;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 4;
    int rr = 0;
    int last_tag = -100;
    bit inj_valid = 1'b0;
    logic [AW-1:0] ch_addr [NUM_CH];
    int            q_due [$];
    logic [DW-1:0] q_dat [$];

    always #5 clk = ~clk;

    cache_fill_arbiter #(.NUM_CH(NUM_CH), .DWIDTH(DW), .AWIDTH(AW),
                         .BLOCK_WORDS(BW), .WORD_BYTES(WB)) dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .fill_data(fill_data),
        .fill_addr(fill_addr), .fsm_data_wen(fsm_data_wen), .fsm_tag_wen(fsm_tag_wen),
        .grant(grant), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive memory returns at negedge, then sample and record new issues.
    task automatic tick();
        @(negedge clk);
        cyc++;
        mem_data_valid = 1'b0;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            mem_data_valid = 1'b1;
            mem_data_in    = q_dat.pop_front();
            void'(q_due.pop_front());
        end else if (inj_valid) begin
            mem_data_valid = 1'b1;
            mem_data_in    = 16'($urandom);
        end
        inj_valid = 1'b0;
        #1;
        if (mem_rd_en === 1'b1) begin
            q_due.push_back(cyc + lat);
            q_dat.push_back(16'($urandom));
        end
    endtask

    task automatic set_addrs();
        for (int i = 0; i < NUM_CH; i++) miss_addr[i*AW +: AW] = ch_addr[i];
    endtask

    function automatic int base_of(input int a);
        return a - (a % (BW * WB));
    endfunction

    function automatic int start_of(input int a);
`ifdef CRITICAL_WORD_FIRST_EN
        return (a % (BW * WB)) / WB;
`else
        return 0;
`endif
    endfunction

    function automatic int waddr(input int a, input int k);
        return (base_of(a) + ((start_of(a) + k) % BW) * WB) % 65536;
    endfunction

    function automatic int pick(input logic [NUM_CH-1:0] req);
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[(rr + i) % NUM_CH]) return (rr + i) % NUM_CH;
        end
        return -1;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_fill_addr"}, fill_addr, 0);
        chk({tag, "_data_wen"}, fsm_data_wen, 0);
        chk({tag, "_tag_wen"}, fsm_tag_wen, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Follow one fill cycle by cycle against the transaction-level expectation.
    task automatic do_fill(input int ch, input int abort_after, input int drop_after,
                           input bit stray, input bit b2b);
        int a, t, gdec, mi, mr, tag_due, oh;
        bit done, acc, is_tag, exp_rd;
        a  = int'(ch_addr[ch]);
        oh = 1 << ch;
        t  = 0;
        while (busy !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        chk("grant_wait", busy, 1);
        if (busy !== 1'b1) return;
        if (b2b) chk("idle_gap", cyc - last_tag, 2);
        gdec = cyc - 1; mi = 0; mr = 0; tag_due = -1; done = 1'b0;
        for (int n = 0; n < 80 && !done; n++) begin
            if (n > 0) tick();
            is_tag = (cyc == tag_due);
            exp_rd = !is_tag && (mi < BW);
            chk("busy", busy, 1);
            chk("grant", grant, oh);
            chk("rd_en", mem_rd_en, exp_rd);
            if (exp_rd) begin
                chk("issue_addr", mem_addr, waddr(a, mi));
                mi++;
            end
            if (drop_after > 0 && mi == drop_after) miss_req[ch] = 1'b0;
            acc = (mem_data_valid === 1'b1) && !is_tag && (mr < BW);
            chk("data_wen", fsm_data_wen, acc ? oh : 0);
            if (acc) begin
                chk("fill_addr", fill_addr, waddr(a, mr));
                chk("fill_data", fill_data, mem_data_in);
                mr++;
                if (abort_after > 0 && mr == abort_after) return;
            end
            chk("tag_wen", fsm_tag_wen, is_tag ? oh : 0);
            if (is_tag) begin
                chk("tag_addr", fill_addr, base_of(a));
                chk("tag_latency", cyc - gdec, 2 + lat + BW - 1);
                last_tag = cyc;
                done = 1'b1;
            end else if (mi == BW && mr == BW && tag_due < 0) begin
                tag_due = cyc + 1;
                if (stray) inj_valid = 1'b1;
            end
        end
        chk("tag_seen", done, 1);
        if (!done) return;
        tick();
        chk("post_busy", busy, 0);
        chk("post_grant", grant, 0);
        chk("post_tag_wen", fsm_tag_wen, 0);
        chk("post_rd_en", mem_rd_en, 0);
        rr = (ch + 1) % NUM_CH;
    endtask

    initial begin
        int ch;
        rst = 1'b0; miss_req = '0; miss_addr = '0;
        mem_data_in = '0; mem_data_valid = 1'b0;
        repeat (2) tick();
        check_quiet("reset");
        rst = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // d-cache fill at 0x1234
        ch_addr[0] = 16'($urandom); ch_addr[1] = 16'h1234; set_addrs();
        miss_req = 2'b10;
        do_fill(1, 0, 0, 1'b0, 1'b0);
        miss_req = 2'b00;

        // stray valid while idle
        inj_valid = 1'b1;
        tick();
        check_quiet("idle_stray");

        // round robin with both requesting continuously
        ch_addr[0] = 16'($urandom); ch_addr[1] = 16'($urandom); set_addrs();
        miss_req = 2'b11;
        for (int k = 0; k < 3; k++) do_fill(pick(miss_req), 0, 0, k == 1, k > 0);
        miss_req = 2'b00;

        // critical-word-first example address
        ch_addr[0] = 16'h123A; set_addrs();
        miss_req = 2'b01;
        do_fill(pick(miss_req), 0, 0, 1'b1, 1'b0);

        // request dropped during ISSUE
        ch_addr[0] = 16'($urandom); set_addrs();
        miss_req = 2'b01;
        do_fill(0, 0, 3, 1'b0, 1'b0);
        miss_req = 2'b00;

        // randomized requests, addresses and memory latency
        for (int it = 0; it < 8; it++) begin
            lat = $urandom_range(1, 6);
            ch_addr[0] = 16'($urandom); ch_addr[1] = 16'($urandom); set_addrs();
            miss_req = NUM_CH'($urandom_range(1, 3));
            ch = pick(miss_req);
            do_fill(ch, 0, 0, 1'($urandom_range(0, 1)), 1'b0);
            miss_req = 2'b00;
        end

        // async reset after the third return
        lat = 4;
        ch_addr[0] = 16'($urandom); ch_addr[1] = 16'($urandom); set_addrs();
        miss_req = 2'b11;
        do_fill(pick(miss_req), 3, 0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1 check_quiet("mid_reset");
        miss_req = 2'b00;
        tick();
        rst = 1'b1;
        rr = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("late_data_wen", fsm_data_wen, 0);
            chk("late_tag_wen", fsm_tag_wen, 0);
            chk("late_busy", busy, 0);
        end

        // recovery fill after reset starts from channel 0
        ch_addr[0] = 16'($urandom); ch_addr[1] = 16'($urandom); set_addrs();
        miss_req = 2'b11;
        do_fill(0, 0, 0, 1'b0, 1'b0);
        miss_req = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
